// File: rtl/tmds_deserializer_decoder.sv
// TMDS receive channel: serial-to-parallel shifter, boundary lock on
// repeated control tokens, and per-character data/control decode.
module tmds_deserializer_decoder #(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic       decoderSerialClock,
    input  logic       resetN,
    input  logic       tmdsSerialIn,
    output logic [7:0] pixelComponent,
    output logic [1:0] controlBus,
    output logic       DE,
    output logic       wordValid,
    output logic       locked
);

    typedef enum logic {SEARCH, LOCKED} state_t;

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    localparam logic [3:0] LOCK_CNT   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_CNT = 4'(UNLOCK_COUNT);

    state_t      state_q, state_d;
    logic [9:0]  shift_q, shift_d;
    logic [3:0]  slot_q, slot_d;
    logic [3:0]  match_q, match_d;
    logic [3:0]  misalign_q, misalign_d;
    logic [7:0]  pix_q, pix_d;
    logic [1:0]  ctl_q, ctl_d;
    logic        de_q, de_d;
    logic        wv_q, wv_d;

    logic        is_ctrl;
    logic [1:0]  ctrl_val;
    logic        boundary;
    logic [3:0]  match_inc;
    logic [3:0]  misalign_inc;

    // Undo the transition-minimising stage: q[9] flags inversion, q[8]
    // selects whether neighbouring bits were chained with XOR or XNOR.
    function automatic logic [7:0] tmds_decode_data(input logic [9:0] q);
        logic [7:0] t;
        logic [7:0] d;
        t    = q[9] ? ~q[7:0] : q[7:0];
        d[0] = t[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        end
        return d;
    endfunction

    assign boundary     = (slot_q == 4'd9);
    assign match_inc    = match_q + 4'd1;
    assign misalign_inc = misalign_q + 4'd1;

    // Recognise the four control tokens in the current window.
    always_comb begin
        is_ctrl  = 1'b1;
        ctrl_val = 2'b00;
        case (shift_q)
            TOK_00:  ctrl_val = 2'b00;
            TOK_01:  ctrl_val = 2'b01;
            TOK_10:  ctrl_val = 2'b10;
            TOK_11:  ctrl_val = 2'b11;
            default: is_ctrl  = 1'b0;
        endcase
    end

    // Lock tracking, slot counting and character decode.
    always_comb begin
        state_d    = state_q;
        shift_d    = {tmdsSerialIn, shift_q[9:1]};
        slot_d     = boundary ? 4'd0 : slot_q + 4'd1;
        match_d    = match_q;
        misalign_d = misalign_q;
        pix_d      = pix_q;
        ctl_d      = ctl_q;
        de_d       = de_q;
        wv_d       = 1'b0;
        case (state_q)
            SEARCH: begin
                de_d = 1'b0;
                if (match_q == 4'd0) begin
                    // First token found: it defines the character phase,
                    // so the next boundary lands exactly 10 cycles later.
                    if (is_ctrl) begin
                        slot_d  = 4'd0;
                        match_d = 4'd1;
                        if (LOCK_CNT == 4'd1) begin
                            state_d    = LOCKED;
                            misalign_d = 4'd0;
                        end
                    end
                end else if (boundary) begin
                    if (is_ctrl) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_CNT) begin
                            state_d    = LOCKED;
                            misalign_d = 4'd0;
                        end
                    end else begin
                        match_d = 4'd0;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    wv_d = 1'b1;
                    if (is_ctrl) begin
                        de_d       = 1'b0;
                        ctl_d      = ctrl_val;
                        misalign_d = 4'd0;
                    end else begin
                        de_d  = 1'b1;
                        pix_d = tmds_decode_data(shift_q);
                    end
                end else if (is_ctrl) begin
                    // Tokens off the boundary mean the phase has slipped.
                    misalign_d = misalign_inc;
                    if (misalign_inc == UNLOCK_CNT) begin
                        state_d = SEARCH;
                        match_d = 4'd0;
                        de_d    = 1'b0;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge decoderSerialClock) begin
        if (!resetN) begin
            state_q    <= SEARCH;
            shift_q    <= '0;
            slot_q     <= '0;
            match_q    <= '0;
            misalign_q <= '0;
            pix_q      <= '0;
            ctl_q      <= '0;
            de_q       <= 1'b0;
            wv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            slot_q     <= slot_d;
            match_q    <= match_d;
            misalign_q <= misalign_d;
            pix_q      <= pix_d;
            ctl_q      <= ctl_d;
            de_q       <= de_d;
            wv_q       <= wv_d;
        end
    end

    assign pixelComponent = pix_q;
    assign controlBus     = ctl_q;
    assign DE             = de_q;
    assign wordValid      = wv_q;
    assign locked         = (state_q == LOCKED);

endmodule

// File: tb/tb_tmds_deserializer_decoder.sv
// Bench for tmds_deserializer_decoder: directed test-plan scenarios with
// literal expectations, then randomized streams checked against a model.
module tb_tmds_deserializer_decoder;

    localparam int LOCK_COUNT   = 4;
    localparam int UNLOCK_COUNT = 4;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       tmdsSerialIn = 1'b0;
    logic [7:0] pixelComponent;
    logic [1:0] controlBus;
    logic       DE;
    logic       wordValid;
    logic       locked;

    int checks = 0;
    int errors = 0;
    int wv_count = 0;

    logic s_rst = 1'b1;
    logic s_bit = 1'b0;

    always #5 clk = ~clk;

    tmds_deserializer_decoder #(
        .LOCK_COUNT  (LOCK_COUNT),
        .UNLOCK_COUNT(UNLOCK_COUNT)
    ) dut (
        .decoderSerialClock(clk),
        .resetN            (resetN),
        .tmdsSerialIn      (tmdsSerialIn),
        .pixelComponent    (pixelComponent),
        .controlBus        (controlBus),
        .DE                (DE),
        .wordValid         (wordValid),
        .locked            (locked)
    );

    // Inputs as seen by the DUT at each rising edge, for the model.
    always @(posedge clk) begin
        s_rst <= resetN;
        s_bit <= tmdsSerialIn;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] tok_word(input int c);
        case (c)
            0:       return 10'b1101010100;
            1:       return 10'b0010101011;
            2:       return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    // Index of the control token held in w ({C1,C0}), or -1.
    function automatic int token_index(input logic [9:0] w);
        for (int c = 0; c < 4; c++) begin
            if (w == tok_word(c)) return c;
        end
        return -1;
    endfunction

    // Data decode by inverting the encoder: search the byte whose
    // XOR/XNOR-chained form matches the (de-inverted) received bits.
    function automatic logic [7:0] ref_decode(input logic [9:0] w);
        logic [7:0] t, qm, dv, r;
        t = w[9] ? ~w[7:0] : w[7:0];
        r = 8'h00;
        for (int d = 0; d < 256; d++) begin
            dv = 8'(d);
            qm[0] = dv[0];
            for (int i = 1; i < 8; i++) begin
                qm[i] = w[8] ? (qm[i-1] ^ dv[i]) : ~(qm[i-1] ^ dv[i]);
            end
            if (qm == t) r = dv;
        end
        return r;
    endfunction

    // Behavioural model plus per-cycle output comparison.
    initial begin : model_cmp
        logic [9:0]  hist;
        logic        m_valid, m_locked, m_de, m_wv;
        logic [7:0]  m_pix;
        logic [1:0]  m_ctl;
        int          m_match, m_mis, m_anchor, cyc, tk;
        logic        on_grid;
        logic [12:0] exp_v, act_v;
        hist = '0; m_valid = 0; m_locked = 0; m_de = 0; m_wv = 0;
        m_pix = '0; m_ctl = '0; m_match = 0; m_mis = 0; m_anchor = 0; cyc = 0;
        forever begin
            @(negedge clk);
            if (!s_rst) begin
                hist = '0; m_locked = 0; m_match = 0; m_mis = 0;
                m_pix = '0; m_ctl = '0; m_de = 0; m_wv = 0; m_valid = 1;
            end else if (m_valid) begin
                tk      = token_index(hist);
                on_grid = (((cyc - m_anchor) % 10) == 0);
                m_wv    = 0;
                if (!m_locked) begin
                    m_de = 0;
                    if (m_match == 0) begin
                        if (tk >= 0) begin
                            m_anchor = cyc + 10;
                            m_match  = 1;
                            if (m_match >= LOCK_COUNT) begin m_locked = 1; m_mis = 0; end
                        end
                    end else if (on_grid) begin
                        if (tk >= 0) begin
                            m_match++;
                            if (m_match == LOCK_COUNT) begin m_locked = 1; m_mis = 0; end
                        end else begin
                            m_match = 0;
                        end
                    end
                end else if (on_grid) begin
                    m_wv = 1;
                    if (tk >= 0) begin
                        m_de = 0; m_ctl = tk[1:0]; m_mis = 0;
                    end else begin
                        m_de = 1; m_pix = ref_decode(hist);
                    end
                end else if (tk >= 0) begin
                    m_mis++;
                    if (m_mis == UNLOCK_COUNT) begin m_locked = 0; m_match = 0; m_de = 0; end
                end
                hist = {s_bit, hist[9:1]};
            end
            cyc++;
            if (m_valid) begin
                if (wordValid) wv_count++;
                exp_v = {m_locked, m_wv, m_de, m_ctl, m_pix};
                act_v = {locked, wordValid, DE, controlBus, pixelComponent};
                check("model{lock,wv,de,ctl,pix}", 32'(act_v), 32'(exp_v));
            end
        end
    end

    task automatic send_bit(input logic b);
        tmdsSerialIn = b;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) send_bit(w[i]);
    endtask

    // Sends w; after its first bit the outputs must show the previous word.
    task automatic word_chk(input logic [9:0] w, input string name,
                            input logic exp_de, input logic [1:0] exp_ctl,
                            input logic [7:0] exp_pix);
        send_bit(w[0]);
        check({name, "_wv"},  32'(wordValid),      32'd1);
        check({name, "_de"},  32'(DE),             32'(exp_de));
        check({name, "_ctl"}, 32'(controlBus),     32'(exp_ctl));
        check({name, "_pix"}, 32'(pixelComponent), 32'(exp_pix));
        for (int i = 1; i < 10; i++) send_bit(w[i]);
    endtask

    // Three junk bits then a 00-token stream until lock; ends on a boundary.
    task automatic lock_up(input string name);
        logic [9:0] t0;
        t0 = tok_word(0);
        wv_count = 0;
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        for (int i = 0; i < LOCK_COUNT; i++) send_word(t0);
        check({name, "_lock_early"}, 32'(locked), 32'd0);
        check({name, "_no_wv"}, 32'(wv_count), 32'd0);
        send_bit(t0[0]);
        check({name, "_lock_on"}, 32'(locked), 32'd1);
        for (int i = 1; i < 10; i++) send_bit(t0[i]);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [9:0] t0;
        int r, nb, nt, nw;
        t0 = tok_word(0);

        // Model pins: hand-decoded characters.
        check("ref_dec_0100000000", 32'(ref_decode(10'b0100000000)), 32'h00);
        check("ref_dec_1000000000", 32'(ref_decode(10'b1000000000)), 32'hFF);
        check("ref_dec_0111111111", 32'(ref_decode(10'b0111111111)), 32'h01);

        resetN = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_outs", 32'({wordValid, DE, controlBus, pixelComponent}), 32'd0);
        resetN = 1'b1;

        lock_up("first");
        word_chk(10'b0100000000, "tok_after_lock", 1'b0, 2'd0, 8'h00);
        word_chk(10'b1000000000, "data_00",        1'b1, 2'd0, 8'h00);
        word_chk(tok_word(3),    "data_ff",        1'b1, 2'd0, 8'hFF);
        word_chk(tok_word(0),    "ctl_11",         1'b0, 2'd3, 8'hFF);
        word_chk(tok_word(1),    "b2b_00",         1'b0, 2'd0, 8'hFF);
        word_chk(tok_word(2),    "b2b_01",         1'b0, 2'd1, 8'hFF);
        word_chk(tok_word(3),    "b2b_10",         1'b0, 2'd2, 8'hFF);
        word_chk(tok_word(0),    "b2b_11",         1'b0, 2'd3, 8'hFF);
        send_word(t0);

        // One-bit slip: lock holds for UNLOCK_COUNT shifted tokens.
        send_bit(1'b0);
        for (int i = 0; i < UNLOCK_COUNT; i++) send_word(t0);
        check("slip_pre_unlock", 32'(locked), 32'd1);
        send_bit(t0[0]);
        check("slip_unlock", 32'(locked), 32'd0);
        for (int i = 1; i < 10; i++) send_bit(t0[i]);
        for (int i = 1; i < LOCK_COUNT; i++) send_word(t0);
        check("slip_relock_early", 32'(locked), 32'd0);
        send_bit(t0[0]);
        check("slip_relock", 32'(locked), 32'd1);
        for (int i = 1; i < 10; i++) send_bit(t0[i]);
        send_word(10'b0111111111);
        word_chk(t0, "relock_data_01", 1'b1, 2'd0, 8'h01);

        // Reset pulse while locked.
        resetN = 1'b0;
        send_bit(1'b1);
        check("midrst_locked", 32'(locked), 32'd0);
        check("midrst_outs", 32'({wordValid, DE, controlBus, pixelComponent}), 32'd0);
        resetN = 1'b1;
        lock_up("after_rst");
        word_chk(10'b1000000000, "after_rst_tok", 1'b0, 2'd0, 8'h00);

        // Randomized streams: token runs, data bursts, slips, resets.
        for (int seg = 0; seg < 120; seg++) begin
            r = int'($urandom_range(0, 99));
            if (r < 5) begin
                resetN = 1'b0;
                send_bit(1'b0);
                resetN = 1'b1;
            end else if (r < 25) begin
                nb = int'($urandom_range(1, 9));
                for (int k = 0; k < nb; k++) send_bit(1'($urandom_range(0, 1)));
            end
            nt = int'($urandom_range(0, 8));
            for (int k = 0; k < nt; k++) send_word(tok_word(int'($urandom_range(0, 3))));
            nw = int'($urandom_range(1, 8));
            for (int k = 0; k < nw; k++) send_word(10'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
